// File: rtl/product_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : product_accumulator_if
// Description : Job/product/result bundle between a multiplier-side producer
//               and the product_accumulator back end.
// Revision    : 1.0 - initial release
// ============================================================================
interface product_accumulator_if #(
    parameter int N     = 8,
    parameter int ACC_W = 2*N+8,
    parameter int CNT_W = 8
);
    logic               start;
    logic [CNT_W-1:0]   len;
    logic               p_valid;
    logic [2*N-1:0]     p;
    logic               out_ready;
    logic               busy;
    logic               acc_valid;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   count;
    logic               overflow;

    // Producer / consumer side
    modport master (
        output start, len, p_valid, p, out_ready,
        input  busy, acc_valid, acc, count, overflow
    );

    // Accumulator side
    modport slave (
        input  start, len, p_valid, p, out_ready,
        output busy, acc_valid, acc, count, overflow
    );
endinterface
`default_nettype wire

// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : product_accumulator
// Description : Sums a programmed number of unsigned 2N-bit products into an
//               ACC_W-bit accumulator and presents the total with a
//               valid/ready handshake. Sticky overflow flags any carry out.
//               Optional macro PRODUCT_ACC_SAT_EN: clamp to all-ones on carry
//               instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module product_accumulator #(
    parameter int N     = 8,
    parameter int ACC_W = 2*N+8,
    parameter int CNT_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    product_accumulator_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q,   acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   len_q,   len_d;
    logic               ovf_q,   ovf_d;

    // One extra bit holds the carry out of the accumulator
    logic [ACC_W:0]     sum_w;
    logic [CNT_W-1:0]   count_inc_w;

    assign sum_w       = {1'b0, acc_q} + {{(ACC_W+1-2*N){1'b0}}, bus.p};
    assign count_inc_w = count_q + CNT_W'(1);

    // State and datapath registers; reset aborts any job in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and accumulate logic
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    len_d   = bus.len;
                    // A zero-length job has nothing to sum: result is ready at once
                    state_d = (bus.len == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (bus.p_valid) begin
                    count_d = count_inc_w;
                    if (sum_w[ACC_W]) begin
                        ovf_d = 1'b1;
                    end
`ifdef PRODUCT_ACC_SAT_EN
                    // Once clamped, stay clamped even if later products are zero
                    if (sum_w[ACC_W] || ovf_q) begin
                        acc_d = '1;
                    end else begin
                        acc_d = sum_w[ACC_W-1:0];
                    end
`else
                    acc_d = sum_w[ACC_W-1:0];
`endif
                    if (count_inc_w == len_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Result is left in acc after handshake until the next start
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy      = (state_q != S_IDLE);
    assign bus.acc_valid = (state_q == S_DONE);
    assign bus.acc       = acc_q;
    assign bus.count     = count_q;
    assign bus.overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_product_accumulator
// Description : Self-checking bench. A default-width accumulator and a narrow
//               (ACC_W=17) accumulator receive identical stimulus; results are
//               compared against the arithmetic sum of each job's products.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_product_accumulator;

    localparam int N      = 8;
    localparam int CNT_W  = 8;
    localparam int W_WIDE = 2*N+8;
    localparam int W_NARR = 17;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  len = '0;
    logic              p_valid = 1'b0;
    logic [2*N-1:0]    p = '0;
    logic              out_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] pq[$];

    always #5 clk = ~clk;

    product_accumulator_if #(.N(N), .ACC_W(W_WIDE), .CNT_W(CNT_W)) ifw ();
    product_accumulator_if #(.N(N), .ACC_W(W_NARR), .CNT_W(CNT_W)) ifn ();

    assign ifw.start = start;  assign ifn.start = start;
    assign ifw.len = len;      assign ifn.len = len;
    assign ifw.p_valid = p_valid; assign ifn.p_valid = p_valid;
    assign ifw.p = p;          assign ifn.p = p;
    assign ifw.out_ready = out_ready; assign ifn.out_ready = out_ready;

    product_accumulator #(.N(N), .ACC_W(W_WIDE), .CNT_W(CNT_W)) u_wide (
        .clk(clk), .rst_n(rst_n), .bus(ifw.slave)
    );
    product_accumulator #(.N(N), .ACC_W(W_NARR), .CNT_W(CNT_W)) u_narr (
        .clk(clk), .rst_n(rst_n), .bus(ifn.slave)
    );

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: the final value of an ACC_W register fed a running total s
    function automatic longint unsigned exp_acc(input longint unsigned s, input int w);
        longint unsigned lim = 64'd1 << w;
        if (s >= lim) begin
`ifdef PRODUCT_ACC_SAT_EN
            return lim - 1;
`else
            return s % lim;
`endif
        end
        return s;
    endfunction

    // Totals only grow, so a carry happened iff the true total reached 2^w
    function automatic longint unsigned exp_ovf(input longint unsigned s, input int w);
        return (s >= (64'd1 << w)) ? 1 : 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_both(input string tag, input longint unsigned s, input int cnt);
        check({tag, ".acc_w"}, ifw.acc, exp_acc(s, W_WIDE));
        check({tag, ".acc_n"}, ifn.acc, exp_acc(s, W_NARR));
        check({tag, ".ovf_w"}, ifw.overflow, exp_ovf(s, W_WIDE));
        check({tag, ".ovf_n"}, ifn.overflow, exp_ovf(s, W_NARR));
        check({tag, ".cnt_w"}, ifw.count, cnt);
        check({tag, ".cnt_n"}, ifn.count, cnt);
    endtask

    // gap_mode: 0 back-to-back, 1 two idle cycles before each product, 2 random
    task automatic run_job(input int gap_mode, input int ready_dly);
        int L;
        int g;
        longint unsigned s;
        L = pq.size();
        s = 0;
        start = 1'b1; len = CNT_W'(L); p_valid = 1'b0;
        step();
        start = 1'b0;
        if (L > 0) begin
            check("accum.busy", ifw.busy, 1);
            check("accum.valid", ifw.acc_valid, 0);
            check_both("accum.clear", 0, 0);
        end
        for (int k = 0; k < L; k++) begin
            g = (gap_mode == 1) ? 2 : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
            for (int j = 0; j < g; j++) begin
                p_valid = 1'b0; p = 16'($urandom); start = 1'($urandom_range(0, 1));
                step();
                check("gap.cnt", ifw.count, k);
                check("gap.acc", ifw.acc, exp_acc(s, W_WIDE));
            end
            p_valid = 1'b1; p = pq[k]; start = 1'($urandom_range(0, 1));
            step();
            s += pq[k];
            check_both("prod", s, k + 1);
            if (k < L - 1) begin
                check("prod.valid", ifw.acc_valid, 0);
            end
        end
        p_valid = 1'b0; start = 1'b0;
        check("done.valid_w", ifw.acc_valid, 1);
        check("done.valid_n", ifn.acc_valid, 1);
        check("done.busy", ifw.busy, 1);
        check_both("done", s, L);
        for (int j = 0; j < ready_dly; j++) begin
            out_ready = 1'b0; start = 1'($urandom_range(0, 1));
            p_valid = 1'($urandom_range(0, 1)); p = 16'($urandom);
            step();
            check("hold.valid", ifw.acc_valid, 1);
            check_both("hold", s, L);
        end
        out_ready = 1'b1; start = 1'b1; p_valid = 1'b1; p = 16'hFFFF;
        step();
        out_ready = 1'b0; start = 1'b0; p_valid = 1'b0;
        check("ret.valid_w", ifw.acc_valid, 0);
        check("ret.valid_n", ifn.acc_valid, 0);
        check("ret.busy", ifw.busy, 0);
        check_both("ret.keep", s, L);
        step();
        check("idle.busy", ifw.busy, 0);
        check("idle.valid", ifw.acc_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        check("rst.busy", ifw.busy, 0);
        check("rst.valid", ifw.acc_valid, 0);
        check_both("rst", 0, 0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // 1: back-to-back products
        pq = '{16'd120, 16'd65025, 16'd254};
        run_job(0, 0);
        check("t1.sum", ifw.acc, 65399);

        // 2: two-cycle gaps
        pq = '{16'd100, 16'd200, 16'd300, 16'd400};
        run_job(1, 0);
        check("t2.sum", ifw.acc, 1000);

        // 3: narrow accumulator overflow
        pq = '{16'd65025, 16'd65025, 16'd65025};
        run_job(0, 0);
`ifdef PRODUCT_ACC_SAT_EN
        check("t3.narrow", ifn.acc, 131071);
`else
        check("t3.narrow", ifn.acc, 64003);
`endif
        check("t3.ovf", ifn.overflow, 1);

        // 4: consumer stalls for 5 cycles
        pq = '{16'd9, 16'd11};
        run_job(0, 5);

        // 5: zero-length job
        pq = {};
        run_job(0, 2);

        // 6: reset in the middle of a 5-product job
        start = 1'b1; len = 8'd5;
        step();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            p_valid = 1'b1; p = 16'd1000;
            step();
        end
        p = 16'd500;
        #2 rst_n = 1'b0;
        #1;
        check("arst.busy", ifw.busy, 0);
        check("arst.valid", ifw.acc_valid, 0);
        check_both("arst", 0, 0);
        p_valid = 1'b0;
        step();
        step();
        @(negedge clk) rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step();
            check("arst.novalid", ifw.acc_valid, 0);
        end
        pq = '{16'd7};
        run_job(0, 0);
        check("t6.sum", ifw.acc, 7);

        // Longest job at maximum products: wide fits, narrow overflows
        pq = {};
        for (int k = 0; k < 255; k++) pq.push_back(16'd65025);
        run_job(0, 1);

        // Randomized jobs
        for (int t = 0; t < 30; t++) begin
            int L;
            pq = {};
            L = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
            for (int k = 0; k < L; k++) begin
                pq.push_back(($urandom_range(0, 3) == 0) ? 16'd65025 : 16'($urandom_range(0, 65025)));
            end
            run_job(2, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
